aes_enc_sched: RTL and testbench

Iterative AES-128 encryption sequencer. It accepts a (key, plaintext) pair over a valid/ready handshake and drives the key input of the existing `key_expansion` block. It waits for the expanded round keys to settle, then steps one `aes_round` datapath through rounds 0..10 and presents the ciphertext over a valid/ready output handshake. It sits between the host/bus-facing wrapper and `key_expansion`, and owns all round sequencing and key-reload decisions.

---
 rtl/aes_pkg.sv | 79 +++++++
 rtl/aes_enc_sched_if.sv | 28 ++
 rtl/aes_round.sv | 17 +
 rtl/aes_enc_sched.sv | 119 +++++++++++
 tb/tb_aes_enc_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: S-box, byte-level round transforms and the
// encrypt sequencer state encoding.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    typedef logic [127:0] state_t;

    typedef enum logic [1:0] {
        ENC_IDLE,
        ENC_KEYWAIT,
        ENC_ROUND,
        ENC_OUT
    } enc_state_e;

    // Entry for input byte b lives at bits [2047-8b -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte i of the state is bits [127-8i -: 8]; row r of column c is byte 4c+r.
    function automatic state_t sub_bytes(input state_t s);
        state_t o;
        for (int i = 0; i < 16; i++) begin
            o[8*i +: 8] = sbox(s[8*i +: 8]);
        end
        return o;
    endfunction

    function automatic state_t shift_rows(input state_t s);
        state_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic state_t mix_columns(input state_t s);
        state_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 8*(4*c)     -: 8];
            a1 = s[127 - 8*(4*c + 1) -: 8];
            a2 = s[127 - 8*(4*c + 2) -: 8];
            a3 = s[127 - 8*(4*c + 3) -: 8];
            o[127 - 8*(4*c)     -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[127 - 8*(4*c + 1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[127 - 8*(4*c + 2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[127 - 8*(4*c + 3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_enc_sched_if.sv
// Request/response handshake plus the key_expansion hookup of the encrypt
// sequencer, bundled so the parent wires one port.
interface aes_enc_sched_if;
    import aes_pkg::*;

    logic           in_valid;
    logic           in_ready;
    state_t         in_key;
    state_t         in_block;
    logic           out_valid;
    logic           out_ready;
    state_t         out_block;
    state_t         ke_key;
    logic [1407:0]  ke_round_keys;
    logic           ke_key_ready;
    logic           busy;
    logic [15:0]    blocks_done;

    modport slave (
        input  in_valid, in_key, in_block, out_ready, ke_round_keys, ke_key_ready,
        output in_ready, out_valid, out_block, ke_key, busy, blocks_done
    );

    modport master (
        output in_valid, in_key, in_block, out_ready, ke_round_keys, ke_key_ready,
        input  in_ready, out_valid, out_block, ke_key, busy, blocks_done
    );
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, optional MixColumns,
// AddRoundKey. Shared by the encrypt and decrypt sequencers.
module aes_round
    import aes_pkg::*;
(
    input  state_t state,
    input  state_t round_key,
    input  logic   final_round,
    output state_t next_state
);

    state_t shifted;

    assign shifted    = shift_rows(sub_bytes(state));
    assign next_state = (final_round ? shifted : mix_columns(shifted)) ^ round_key;

endmodule

// File: rtl/aes_enc_sched.sv
// Iterative AES-128 encrypt sequencer: accepts (key, block), reloads
// key_expansion only when the key changes, then runs rounds 0..10 one per cycle.
module aes_enc_sched
    import aes_pkg::*;
#(
    parameter int KEY_SETTLE = 2
) (
    input  logic            clk,
    input  logic            reset,
    aes_enc_sched_if.slave  bus
);

    enc_state_e  state_q, state_d;
    logic [3:0]  r_q, r_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        key_valid_q, key_valid_d;
    state_t      ke_key_q, ke_key_d;
    state_t      st_q, st_d;
    logic [15:0] blocks_done_q, blocks_done_d;

    state_t rk;
    state_t round_out;
    logic   accept;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        rk = bus.ke_round_keys[1407 - 128 * int'(r_q) -: 128];
    end

    aes_round u_round (
        .state       (st_q),
        .round_key   (rk),
        .final_round (r_q == 4'(NUM_ROUNDS)),
        .next_state  (round_out)
    );

    // NOTE: every target gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        r_d           = r_q;
        cnt_d         = cnt_q;
        key_valid_d   = key_valid_q;
        ke_key_d      = ke_key_q;
        st_d          = st_q;
        blocks_done_d = blocks_done_q;

        unique case (state_q)
            ENC_IDLE: begin
                if (accept) begin
                    st_d = bus.in_block;
                    // Reload only when the expanded keys could be stale.
                    if (!key_valid_q || bus.in_key != ke_key_q) begin
                        ke_key_d    = bus.in_key;
                        key_valid_d = 1'b1;
                        cnt_d       = 3'(KEY_SETTLE - 1);
                        state_d     = ENC_KEYWAIT;
                    end else begin
                        r_d     = 4'd0;
                        state_d = ENC_ROUND;
                    end
                end
            end
            ENC_KEYWAIT: begin
                if (cnt_q == 3'd0) begin
                    r_d     = 4'd0;
                    state_d = ENC_ROUND;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ENC_ROUND: begin
                st_d = (r_q == 4'd0) ? (st_q ^ rk) : round_out;
                if (r_q == 4'(NUM_ROUNDS)) begin
                    r_d     = 4'd0;
                    state_d = ENC_OUT;
                end else begin
                    r_d = r_q + 4'd1;
                end
            end
            ENC_OUT: begin
                if (bus.out_ready) begin
                    blocks_done_d = blocks_done_q + 16'd1;
                    state_d       = ENC_IDLE;
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ENC_IDLE;
            r_q           <= 4'd0;
            cnt_q         <= 3'd0;
            key_valid_q   <= 1'b0;
            ke_key_q      <= '0;
            st_q          <= '0;
            blocks_done_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            key_valid_q   <= key_valid_d;
            ke_key_q      <= ke_key_d;
            st_q          <= st_d;
            blocks_done_q <= blocks_done_d;
        end
    end

    assign bus.in_ready    = (state_q == ENC_IDLE) && bus.ke_key_ready;
    assign bus.out_valid   = (state_q == ENC_OUT);
    assign bus.out_block   = (state_q == ENC_OUT) ? st_q : '0;
    assign bus.ke_key      = ke_key_q;
    assign bus.busy        = (state_q != ENC_IDLE);
    assign bus.blocks_done = blocks_done_q;

endmodule

// File: tb/tb_aes_enc_sched.sv
// Directed bench for aes_enc_sched: FIPS-197 vectors, key reuse/reload latency,
// backpressure, readiness gating, counter wrap and mid-operation reset.
module tb_aes_enc_sched;
    import aes_pkg::*;

    localparam int KS = 2;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    logic [15:0] exp_done;

    aes_enc_sched_if bus ();

    aes_enc_sched #(.KEY_SETTLE(KS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for key_expansion: round keys reflect ke_key only KS edges later.
    function automatic logic [1407:0] expand_key(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [7:0]    rcon [10];
        logic [31:0]   t;
        logic [1407:0] o;
        rcon = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
                t = t ^ {rcon[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) o[1407 - 32*i -: 32] = w[i];
        return o;
    endfunction

    logic [127:0] ke_pipe [KS];
    always @(posedge clk) begin
        ke_pipe[0] <= bus.ke_key;
        for (int i = 1; i < KS; i++) ke_pipe[i] <= ke_pipe[i-1];
    end
    assign bus.ke_round_keys = expand_key(ke_pipe[KS-1]);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one request from a negedge, checks ke_key after accept, latency,
    // ciphertext, optional backpressure hold and the completion count.
    task automatic run_block(input string tag, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int lat, input int hold,
                             input bit drop_rdy);
        int guard;
        int n;
        bus.in_valid  = 1'b1;
        bus.in_key    = key;
        bus.in_block  = pt;
        bus.out_ready = (hold == 0);
        #1;
        guard = 0;
        while (!bus.in_ready && guard < 20) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check({tag, " accept"}, bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_key   = ~key;
        bus.in_block = ~pt;
        if (drop_rdy) bus.ke_key_ready = 1'b0;
        check({tag, " ke_key"}, bus.ke_key, key);
        n = 1;
        while (!bus.out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, 128'(n), 128'(lat));
        check({tag, " ct"}, bus.out_block, ct);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold ct"}, bus.out_block, ct);
            check({tag, " hold valid"}, bus.out_valid, 1'b1);
            check({tag, " hold in_ready"}, bus.in_ready, 1'b0);
        end
        bus.ke_key_ready = 1'b1;
        bus.out_ready    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_done = exp_done + 16'd1;
        check({tag, " idle"}, bus.busy, 1'b0);
        check({tag, " out_valid low"}, bus.out_valid, 1'b0);
        check({tag, " blocks_done"}, bus.blocks_done, exp_done);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests          = 0;
        n_fail           = 0;
        exp_done         = 16'd0;
        reset            = 1'b1;
        bus.ke_key_ready = 1'b0;
        bus.in_valid     = 1'b1;
        bus.in_key       = KEY_C1;
        bus.in_block     = PT_C1;
        bus.out_ready    = 1'b1;
        #1;
        check("rst out_valid", bus.out_valid, 1'b0);
        check("rst out_block", bus.out_block, '0);
        check("rst busy", bus.busy, 1'b0);
        check("rst blocks_done", bus.blocks_done, 16'd0);
        check("rst ke_key", bus.ke_key, '0);
        check("rst in_ready", bus.in_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Request pending while key_expansion is not ready: must not be taken.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("notready in_ready", bus.in_ready, 1'b0);
            check("notready busy", bus.busy, 1'b0);
        end
        bus.ke_key_ready = 1'b1;

        run_block("c1 reload", KEY_C1, PT_C1, CT_C1, 12 + KS, 0, 1'b0);
        run_block("b change", KEY_B, PT_B, CT_B, 12 + KS, 0, 1'b0);
        run_block("b reuse", KEY_B, PT_B, CT_B, 12, 0, 1'b0);
        check("reuse count", bus.blocks_done, 16'd3);
        run_block("b backpressure", KEY_B, PT_B, CT_B, 12, 5, 1'b1);

        // Preload the completion counter just below wrap.
        force dut.blocks_done_q = 16'hffff;
        @(posedge clk);
        @(negedge clk);
        release dut.blocks_done_q;
        exp_done = 16'hffff;
        check("preload count", bus.blocks_done, 16'hffff);
        run_block("wrap", KEY_B, PT_B, CT_B, 12, 0, 1'b0);
        check("wrap count", bus.blocks_done, 16'd0);

        // Reset while round 5 is in flight.
        bus.in_valid = 1'b1;
        bus.in_key   = KEY_C1;
        bus.in_block = PT_C1;
        #1;
        check("midrst accept", bus.in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("midrst busy before", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst busy", bus.busy, 1'b0);
        check("midrst out_valid", bus.out_valid, 1'b0);
        check("midrst out_block", bus.out_block, '0);
        check("midrst ke_key", bus.ke_key, '0);
        check("midrst blocks_done", bus.blocks_done, 16'd0);
        @(negedge clk);
        reset    = 1'b0;
        exp_done = 16'd0;

        // All-zero key equals the reset ke_key, yet key_valid=0 must still force a reload.
        run_block("zero key", '0, '0, CT_Z, 12 + KS, 0, 1'b0);
        run_block("c1 after rst", KEY_C1, PT_C1, CT_C1, 12 + KS, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
